// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the iterative radix-2 FFT.
package fft_pkg;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      UNLOAD  = 2'd2
   } state_t;

   localparam int CPLX_DW = 16;

   typedef struct packed {
      logic signed [CPLX_DW-1:0] re;
      logic signed [CPLX_DW-1:0] im;
   } cplx_t;

   localparam real PI = 3.14159265358979323846;

   function automatic int unsigned bitrev(input int unsigned v, input int nbits);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if (i < nbits) r = (r << 1) | ((v >> i) & 32'd1);
      end
      return r;
   endfunction

   // Round to nearest (ties away from zero), then clip to the symmetric range.
   function automatic int tw_quant(input real x, input int tw);
      real r;
      int  q;
      int  lim;
      lim = (1 << (tw - 1)) - 1;
      r   = x * real'(lim + 1);
      q   = (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
      if (q > lim)  q = lim;
      if (q < -lim) q = -lim;
      return q;
   endfunction

   function automatic int tw_re(input int k, input int n_log2, input int tw);
      return tw_quant($cos(2.0 * PI * real'(k) / real'(1 << n_log2)), tw);
   endfunction

   function automatic int tw_im(input int k, input int n_log2, input int tw);
      return tw_quant(-$sin(2.0 * PI * real'(k) / real'(1 << n_log2)), tw);
   endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational DIT butterfly with per-stage halving and k=0 multiplier bypass.
// FFT_ROUND_EN selects round-half-up on every shift instead of truncation.
module fft_butterfly #(
   parameter int DW = 16,
   parameter int TW = 16
) (
   input  logic [DW-1:0] i_a_re,
   input  logic [DW-1:0] i_a_im,
   input  logic [DW-1:0] i_b_re,
   input  logic [DW-1:0] i_b_im,
   input  logic [TW-1:0] i_w_re,
   input  logic [TW-1:0] i_w_im,
   input  logic          i_bypass,
   output logic [DW-1:0] o_a_re,
   output logic [DW-1:0] o_a_im,
   output logic [DW-1:0] o_b_re,
   output logic [DW-1:0] o_b_im
);
   localparam int PW = DW + TW + 1;
   localparam int XW = DW + 2;

`ifdef FFT_ROUND_EN
   localparam logic signed [PW-1:0] RND_P = PW'(1) << (TW - 2);
   localparam logic signed [XW-1:0] RND_S = XW'(1);
`else
   localparam logic signed [PW-1:0] RND_P = '0;
   localparam logic signed [XW-1:0] RND_S = '0;
`endif

   logic signed [PW-1:0] w_br, w_bi, w_wr, w_wi;
   logic signed [PW-1:0] w_pr_full, w_pi_full;
   logic signed [XW-1:0] w_p_re, w_p_im, w_a_re, w_a_im;
   logic signed [XW-1:0] w_sa_re, w_sa_im, w_sb_re, w_sb_im;

   assign w_br = PW'($signed(i_b_re));
   assign w_bi = PW'($signed(i_b_im));
   assign w_wr = PW'($signed(i_w_re));
   assign w_wi = PW'($signed(i_w_im));

   assign w_pr_full = w_wr * w_br - w_wi * w_bi;
   assign w_pi_full = w_wr * w_bi + w_wi * w_br;

   assign w_p_re = i_bypass ? XW'($signed(i_b_re)) : XW'((w_pr_full + RND_P) >>> (TW - 1));
   assign w_p_im = i_bypass ? XW'($signed(i_b_im)) : XW'((w_pi_full + RND_P) >>> (TW - 1));

   assign w_a_re = XW'($signed(i_a_re));
   assign w_a_im = XW'($signed(i_a_im));

   assign w_sa_re = w_a_re + w_p_re + RND_S;
   assign w_sa_im = w_a_im + w_p_im + RND_S;
   assign w_sb_re = w_a_re - w_p_re + RND_S;
   assign w_sb_im = w_a_im - w_p_im + RND_S;

   assign o_a_re = DW'(w_sa_re >>> 1);
   assign o_a_im = DW'(w_sa_im >>> 1);
   assign o_b_re = DW'(w_sb_re >>> 1);
   assign o_b_im = DW'(w_sb_im >>> 1);

endmodule

// File: rtl/fft_radix2_iter.sv
// Iterative N-point radix-2 DIT FFT: one shared butterfly over an in-place register RAM.
// Rounding mode of the butterfly is selected by FFT_ROUND_EN (see fft_butterfly).
//
// state   | meaning
// LOAD    | accept N samples, stored at bit-reversed addresses
// COMPUTE | one butterfly per cycle, N/2 per stage, N_LOG2 stages
// UNLOAD  | present bins in natural order until N handshakes
module fft_radix2_iter #(
   parameter int N_LOG2 = 3,
   parameter int DW     = 16,
   parameter int TW     = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_re,
   input  logic [DW-1:0] in_im,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_re,
   output logic [DW-1:0] out_im,
   output logic          busy
);
   import fft_pkg::*;

   localparam int N  = 1 << N_LOG2;
   localparam int NH = N / 2;
   localparam int AW = N_LOG2;
   localparam int KW = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;
   localparam int SW = 4;

   state_t        r_state, w_state_nxt;
   logic [AW-1:0] r_idx, r_j, r_oidx;
   logic [SW-1:0] r_s;
   logic [DW-1:0] r_ram_re [N];
   logic [DW-1:0] r_ram_im [N];

   logic          w_in_fire, w_last_bfly;
   logic [AW-1:0] w_half, w_lo, w_top, w_bot, w_bidx;
   logic [KW-1:0] w_k;
   logic [TW-1:0] w_rom_re [NH];
   logic [TW-1:0] w_rom_im [NH];
   logic [DW-1:0] w_na_re, w_na_im, w_nb_re, w_nb_im;

   for (genvar g = 0; g < NH; g++) begin : g_rom
      assign w_rom_re[g] = TW'(tw_re(g, N_LOG2, TW));
      assign w_rom_im[g] = TW'(tw_im(g, N_LOG2, TW));
   end

   assign w_in_fire   = in_valid && (r_state == LOAD);
   assign w_last_bfly = (r_s == SW'(N_LOG2 - 1)) && (r_j == AW'(NH - 1));

   always_comb begin
      w_half = AW'(1) << r_s;
      w_lo   = r_j & (w_half - AW'(1));
      w_top  = ((r_j >> r_s) << (r_s + SW'(1))) + w_lo;
      w_bot  = w_top + w_half;
      w_k    = KW'(w_lo << (SW'(N_LOG2 - 1) - r_s));
      w_bidx = AW'(bitrev(32'(r_idx), N_LOG2));
   end

   fft_butterfly #(.DW(DW), .TW(TW)) u_bfly (
      .i_a_re   (r_ram_re[w_top]),
      .i_a_im   (r_ram_im[w_top]),
      .i_b_re   (r_ram_re[w_bot]),
      .i_b_im   (r_ram_im[w_bot]),
      .i_w_re   (w_rom_re[w_k]),
      .i_w_im   (w_rom_im[w_k]),
      .i_bypass (w_k == '0),
      .o_a_re   (w_na_re),
      .o_a_im   (w_na_im),
      .o_b_re   (w_nb_re),
      .o_b_im   (w_nb_im)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= LOAD;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      case (r_state)
         LOAD: begin
            in_ready = 1'b1;
            if (w_in_fire && (r_idx == AW'(N - 1))) w_state_nxt = COMPUTE;
         end
         COMPUTE: begin
            busy = 1'b1;
            if (w_last_bfly) w_state_nxt = UNLOAD;
         end
         UNLOAD: begin
            out_valid = 1'b1;
            if (out_ready && (r_oidx == AW'(N - 1))) w_state_nxt = LOAD;
         end
         default: w_state_nxt = LOAD;
      endcase
   end

   // Counters wrap naturally at N; r_s is cleared explicitly on the last butterfly.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx  <= '0;
         r_j    <= '0;
         r_s    <= '0;
         r_oidx <= '0;
      end else begin
         case (r_state)
            LOAD:    if (w_in_fire) r_idx <= r_idx + AW'(1);
            COMPUTE: begin
               if (w_last_bfly) begin
                  r_j <= '0;
                  r_s <= '0;
               end else if (r_j == AW'(NH - 1)) begin
                  r_j <= '0;
                  r_s <= r_s + SW'(1);
               end else begin
                  r_j <= r_j + AW'(1);
               end
            end
            UNLOAD:  if (out_ready) r_oidx <= r_oidx + AW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_in_fire) begin
            r_ram_re[w_bidx] <= in_re;
            r_ram_im[w_bidx] <= in_im;
         end else if (r_state == COMPUTE) begin
            r_ram_re[w_top] <= w_na_re;
            r_ram_im[w_top] <= w_na_im;
            r_ram_re[w_bot] <= w_nb_re;
            r_ram_im[w_bot] <= w_nb_im;
         end
      end
   end

   assign out_re = r_ram_re[r_oidx];
   assign out_im = r_ram_im[r_oidx];

endmodule
